furv_dmem: RTL and testbench

//  Data-side memory system for the furv core, directly downstream of its load/store port.

---
 rtl/furv_dmem.sv | 202 ++++++++++++++++++++
 tb/tb_furv_dmem.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/furv_dmem.sv
// furv_dmem: data-side memory system for the furv core.
// Decodes the core's single-beat load/store into word RAM or an MMIO window
// (TX byte FIFO, status register, free-running cycle counter).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_en, mem_read      access strobe and direction (1 = read)
//   addr, wdata           byte address (word granular) and write data
//   rdata                 registered read data
//   tx_data, tx_valid     FIFO head byte / non-empty, registered
//   tx_ready              consumer accepts head at posedge when tx_valid
//   fault                 one-cycle pulse on an unmapped MMIO access
module furv_dmem #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fault
);

    localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    // MMIO word offsets (byte offset >> 2)
    localparam logic [29:0] OFS_TXDATA = 30'h0;
    localparam logic [29:0] OFS_STATUS = 30'h1;
    localparam logic [29:0] OFS_CYCLE  = 30'h2;

    // Storage
    logic [31:0]        r_ram  [RAM_WORDS];
    logic [7:0]         r_fifo [FIFO_DEPTH];

    // Registered state
    logic [31:0]        r_rdata;
    logic               r_fault;
    logic [31:0]        r_cycle;
    logic               r_overflow;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;

    // Combinational decode / next-state
    logic               w_is_mmio;
    logic [29:0]        w_ofs_word;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_sel_tx;
    logic               w_sel_status;
    logic               w_sel_cycle;
    logic               w_sel_unmapped;
    logic               w_ram_we;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [FIFO_AW-1:0] w_rd_nxt;
    logic [FIFO_AW-1:0] w_wr_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [7:0]         w_tx_data_nxt;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata_nxt;
    logic               w_fault_nxt;
    logic [31:0]        w_cycle_nxt;
    logic               w_overflow_nxt;

    // Address decode; MMIO offset compared on word granularity
    always_comb begin
        w_is_mmio      = (addr >= MMIO_BASE);
        w_ofs_word     = addr[31:2] - MMIO_BASE[31:2];
        w_ram_idx      = addr[RAM_AW+1:2];
        w_sel_tx       = 1'b0;
        w_sel_status   = 1'b0;
        w_sel_cycle    = 1'b0;
        w_sel_unmapped = 1'b0;
        if (mem_en && w_is_mmio) begin
            case (w_ofs_word)
                OFS_TXDATA: w_sel_tx       = 1'b1;
                OFS_STATUS: w_sel_status   = 1'b1;
                OFS_CYCLE:  w_sel_cycle    = 1'b1;
                default:    w_sel_unmapped = 1'b1;
            endcase
        end
        w_ram_we = mem_en && !mem_read && !w_is_mmio;
    end

    // FIFO control: push may ride along a pop even when full
    always_comb begin
        w_full      = (r_count == CNT_W'(FIFO_DEPTH));
        w_empty     = (r_count == '0);
        w_pop       = r_tx_valid && tx_ready;
        w_push      = w_sel_tx && !mem_read && (!w_full || w_pop);
        w_drop      = w_sel_tx && !mem_read && w_full && !w_pop;
        w_rd_nxt    = r_rd_ptr + FIFO_AW'(w_pop);
        w_wr_nxt    = r_wr_ptr + FIFO_AW'(w_push);
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
        // Head register: the byte being pushed this edge lands in the slot
        // the new read pointer names only when it becomes the head.
        if (w_count_nxt == '0) begin
            w_tx_data_nxt = 8'h00;
        end else if (w_push && (w_rd_nxt == r_wr_ptr)) begin
            w_tx_data_nxt = wdata[7:0];
        end else begin
            w_tx_data_nxt = r_fifo[w_rd_nxt];
        end
    end

    // Read mux, fault, counter and overflow next-state
    always_comb begin
        // count field sits at [13:6], flags at [2:0]
        w_status       = {18'b0, 8'(r_count), 3'b0, r_overflow, w_empty, w_full};
        w_rdata_nxt    = r_rdata;
        w_fault_nxt    = w_sel_unmapped;
        w_overflow_nxt = r_overflow;
        // The load edge itself counts, so the next read sees wdata+1
        w_cycle_nxt    = r_cycle + 32'd1;

        if (mem_en && mem_read) begin
            if (!w_is_mmio) begin
                w_rdata_nxt = r_ram[w_ram_idx];
            end else if (w_sel_status) begin
                w_rdata_nxt = w_status;
            end else if (w_sel_cycle) begin
                w_rdata_nxt = r_cycle;
            end else begin
                w_rdata_nxt = 32'd0;
            end
        end

        if (mem_en && !mem_read) begin
            if (w_sel_cycle) begin
                w_cycle_nxt = wdata + 32'd1;
            end
            if (w_sel_status) begin
                w_overflow_nxt = 1'b0;
            end else if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end
        end
    end

    // Control/state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata    <= 32'd0;
            r_fault    <= 1'b0;
            r_cycle    <= 32'd0;
            r_overflow <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_rdata    <= w_rdata_nxt;
            r_fault    <= w_fault_nxt;
            r_cycle    <= w_cycle_nxt;
            r_overflow <= w_overflow_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_count    <= w_count_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= (w_count_nxt != '0);
        end
    end

    // Word RAM, contents not reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    // FIFO storage, contents not reset (pointers define validity)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= wdata[7:0];
        end
    end

    assign rdata    = r_rdata;
    assign fault    = r_fault;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_furv_dmem.sv
// tb_furv_dmem: directed self-checking bench for furv_dmem.
module tb_furv_dmem;

    localparam logic [31:0] MB  = 32'h8000_0000;
    localparam logic [31:0] TXD = MB;
    localparam logic [31:0] STS = MB + 32'h4;
    localparam logic [31:0] CYC = MB + 32'h8;
    localparam logic [31:0] BAD = MB + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fault;

    int total = 0;
    int bad   = 0;

    furv_dmem #(
        .RAM_WORDS (1024),
        .MMIO_BASE (MB),
        .FIFO_DEPTH(8)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_en  (mem_en),
        .mem_read(mem_read),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access per cycle: drive at negedge, sample #1 after posedge
    task automatic acc(input logic en, input logic rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_en   = en;
        mem_read = rd;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        acc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        acc(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle();
        acc(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp3 [8];
        rst_n    = 1'b0;
        mem_en   = 1'b0;
        mem_read = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        tx_ready = 1'b0;
        #1;
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_txv", 32'(tx_valid), 32'd0);
        check_eq("rst_txd", 32'(tx_data), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: RAM write/read and alias
        wr(32'h40, 32'h1234_5678);
        rd(32'h40);
        check_eq("ram_rd", rdata, 32'h1234_5678);
        rd(32'h40 + 32'd4096);
        check_eq("ram_alias", rdata, 32'h1234_5678);
        idle();
        check_eq("rdata_hold", rdata, 32'h1234_5678);

        // 2: fill, overflow, drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(TXD, 32'(i));
        check_eq("txdata_rd0", 32'(tx_valid), 32'd1);
        rd(STS);
        check_eq("sts_full_ovf", rdata, 32'h0000_0205);
        rd(TXD);
        check_eq("txdata_rd", rdata, 32'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drain_v%0d", i), 32'(tx_valid), 32'd1);
            check_eq($sformatf("drain_d%0d", i), 32'(tx_data), 32'(i));
            idle();
        end
        check_eq("drain_empty", 32'(tx_valid), 32'd0);
        rd(STS);
        check_eq("sts_empty_ovf", rdata, 32'h0000_0006);

        // 3: push+pop while full
        tx_ready = 1'b0;
        wr(STS, 32'd0);
        for (int i = 0; i < 8; i++) wr(TXD, 32'h10 + 32'(i));
        tx_ready = 1'b1;
        wr(TXD, 32'hAA);
        tx_ready = 1'b0;
        rd(STS);
        check_eq("sts_pushpop", rdata, 32'h0000_0201);
        exp3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("pp_d%0d", i), 32'(tx_data), 32'(exp3[i]));
            idle();
        end
        check_eq("pp_empty", 32'(tx_valid), 32'd0);

        // 4: cycle counter load and wrap
        wr(CYC, 32'hFFFF_FFFE);
        rd(CYC);
        check_eq("cyc_load", rdata, 32'hFFFF_FFFF);
        rd(CYC);
        check_eq("cyc_wrap", rdata, 32'h0000_0000);

        // 5: unmapped MMIO
        rd(32'h40);
        check_eq("pre_fault_rd", rdata, 32'h1234_5678);
        check_eq("pre_fault", 32'(fault), 32'd0);
        rd(BAD);
        check_eq("bad_rd_data", rdata, 32'd0);
        check_eq("bad_rd_fault", 32'(fault), 32'd1);
        idle();
        check_eq("fault_clr", 32'(fault), 32'd0);
        wr(BAD, 32'hFFFF_FFFF);
        check_eq("bad_wr_fault", 32'(fault), 32'd1);
        idle();
        check_eq("fault_clr2", 32'(fault), 32'd0);
        rd(STS);
        check_eq("bad_wr_sts", rdata, 32'h0000_0002);
        rd(32'h40);
        check_eq("bad_wr_ram", rdata, 32'h1234_5678);

        // 6: reset mid-operation
        tx_ready = 1'b0;
        for (int i = 1; i <= 3; i++) wr(TXD, 32'(i));
        check_eq("q3_valid", 32'(tx_valid), 32'd1);
        rd(32'h40);
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b1;
        addr     = CYC;
        rst_n    = 1'b0;
        #1;
        check_eq("mid_rst_txv", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_rdata", rdata, 32'd0);
        check_eq("mid_rst_txd", 32'(tx_data), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_cyc", rdata, 32'd0);
        rd(STS);
        check_eq("post_rst_sts", rdata, 32'h0000_0002);
        rd(32'h40);
        check_eq("post_rst_ram", rdata, 32'h1234_5678);
        check_eq("post_rst_txv", 32'(tx_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
